// File: rtl/rgb_matrix_pkg.sv
// rtl/rgb_matrix_pkg.sv - shared constants for the 25-LED RGB matrix blocks
package rgb_matrix_pkg;

  localparam int NUM_LEDS   = 25;
  localparam int LED_ADDR_W = 5;
  localparam int NUM_CHANS  = 3;

  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;

  localparam logic [0:0] SWAP_IDLE    = 1'b0;
  localparam logic [0:0] SWAP_PENDING = 1'b1;

  // A write target exists only for LEDs 0..24 and channels R/G/B.
  function automatic logic wr_target_valid(input logic [LED_ADDR_W-1:0] addr,
                                           input logic [1:0] chan);
    return (addr < LED_ADDR_W'(NUM_LEDS)) && (chan <= CH_B);
  endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// rtl/pwm_tick_gen.sv - prescaler plus shared PWM counter with period marker
module pwm_tick_gen #(
  parameter int DEPTH    = 4,
  parameter int PRESCALE = 1024
) (
  input  logic             clk,
  input  logic             rst,
  output logic             tick,
  output logic [DEPTH-1:0] pwm_cnt,
  output logic             period_end
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
  // Counting stops one short of full scale so the top level is always on.
  localparam logic [DEPTH-1:0] CNT_LAST = DEPTH'((1 << DEPTH) - 2);

  logic [PS_W-1:0] pre_cnt;

  assign tick       = (pre_cnt == PS_LAST);
  assign period_end = tick && (pwm_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else if (tick) begin
      if (pwm_cnt == CNT_LAST) begin
        pwm_cnt <= '0;
      end else begin
        pwm_cnt <= pwm_cnt + DEPTH'(1);
      end
    end
  end

endmodule

// File: rtl/rgb_frame_scheduler.sv
// rtl/rgb_frame_scheduler.sv - double-buffered RGB frame store driving matrix PWM
module rgb_frame_scheduler
  import rgb_matrix_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int PRESCALE = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [LED_ADDR_W-1:0] wr_addr,
  input  logic [1:0]            wr_chan,
  input  logic [DEPTH-1:0]      wr_data,
  output logic                  wr_err,
  input  logic                  swap_req,
  output logic                  swap_pending,
  output logic                  swap_done,
  input  logic                  blank,
  output logic                  period_start,
  output logic [NUM_LEDS-1:0]   R,
  output logic [NUM_LEDS-1:0]   G,
  output logic [NUM_LEDS-1:0]   B
);

  logic             tick;
  logic [DEPTH-1:0] pwm_cnt;
  logic             period_end;

  logic [DEPTH-1:0] shadow [NUM_LEDS][NUM_CHANS];
  logic [DEPTH-1:0] active [NUM_LEDS][NUM_CHANS];

  logic [0:0] swap_state;
  logic       wr_ok;
  logic       commit;

  pwm_tick_gen #(
    .DEPTH    (DEPTH),
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .pwm_cnt    (pwm_cnt),
    .period_end (period_end)
  );

  assign wr_ok        = wr_en && wr_target_valid(wr_addr, wr_chan);
  assign swap_pending = (swap_state == SWAP_PENDING);
  assign commit       = swap_pending && period_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        for (int c = 0; c < NUM_CHANS; c++) begin
          shadow[i][c] <= '0;
        end
      end
    end else if (wr_ok) begin
      shadow[wr_addr][wr_chan] <= wr_data;
    end
  end

  // The copy samples shadow before any same-edge write lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        for (int c = 0; c < NUM_CHANS; c++) begin
          active[i][c] <= '0;
        end
      end
    end else if (commit) begin
      active <= shadow;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      swap_state <= SWAP_IDLE;
      swap_done  <= 1'b0;
    end else begin
      swap_done <= commit;
      case (swap_state)
        SWAP_IDLE:    if (swap_req) swap_state <= SWAP_PENDING;
        SWAP_PENDING: if (period_end) swap_state <= SWAP_IDLE;
        default:      swap_state <= SWAP_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_err       <= 1'b0;
      period_start <= 1'b0;
    end else begin
      wr_err       <= wr_en && !wr_ok;
      period_start <= period_end;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      R <= '0;
      G <= '0;
      B <= '0;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        R[i] <= !blank && (active[i][CH_R] > pwm_cnt);
        G[i] <= !blank && (active[i][CH_G] > pwm_cnt);
        B[i] <= !blank && (active[i][CH_B] > pwm_cnt);
      end
    end
  end

endmodule
